// File: rtl/montexp_pkg.sv
// -----------------------------------------------------------------------------
// montexp_pkg
//   Shared types and elaboration helpers for the windowed Montgomery
//   exponentiator.
//   - state_t     : controller states
//   - digit_count : number of k-bit exponent digits
//   - idx_width   : width of the digit index (must be able to hold D)
// -----------------------------------------------------------------------------
package montexp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOMONT,
    TABLE,
    SCAN,
    SQR,
    MUL,
    FROMMONT,
    DONE
  } state_t;

  function automatic int digit_count(input int ewidth, input int window);
    return ewidth / window;
  endfunction

  function automatic int idx_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage : montexp_pkg

// File: rtl/montexp_window_montmult.sv
// -----------------------------------------------------------------------------
// montmult
//   Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-WIDTH mod n.
//   Operands are captured on start. The result is valid with a one-cycle done
//   pulse WIDTH cycles later. Inputs a and b must be < n, and n must be odd.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a multiplication (ignored while busy)
//   a, b          multiplicands (captured on start)
//   n             modulus, held stable by the caller for the whole operation
//   n_prime       -n^-1 mod 2^WIDTH; radix-2 only needs bit 0, which is 1 for odd n
//   result        fully reduced product, valid when done is high
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module montmult #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] n_prime,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH+1:0] t_q;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] t_next;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  // For odd n the quotient bit is simply the parity of the partial sum.
  logic unused_np;
  assign unused_np = ^n_prime;

  // Invariant t < 2n keeps every partial sum below 4n, so two extra bits suffice.
  always_comb begin
    sum = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    if (sum[0]) begin
      sum = sum + {2'b00, n};
    end
    t_next = sum >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q <= 1'b1;
          a_q    <= a;
          b_q    <= b;
          t_q    <= '0;
          cnt_q  <= '0;
        end
      end else begin
        t_q   <= t_next;
        a_q   <= a_q >> 1;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LastBit) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= (t_next >= {2'b00, n}) ? WIDTH'(t_next - {2'b00, n})
                                             : WIDTH'(t_next);
        end
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule : montmult

// File: rtl/montexp_window.sv
// -----------------------------------------------------------------------------
// montexp_window
//   Fixed-window (2^WINDOW-ary) Montgomery modular exponentiator:
//   result = base^exponent mod modulus. It converts into and out of the
//   Montgomery domain with the caller-supplied r2_mod, builds a 2^k entry
//   power table, then scans the exponent MSB-first using one montmult.
//   Build option: define MONTEXP_CT_EN for constant-time operation (no
//   skipping of zero digits, a fixed number of multiplications).
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   base, exponent       operands (base < modulus)
//   modulus, n_prime     N (odd, > 1) and -N^-1 mod 2^WIDTH
//   r2_mod               R^2 mod N, R = 2^WIDTH
//   out_valid/out_ready  result handshake; result is held until accepted
//   result               base^exponent mod N, normal domain
//   busy                 high in every state except IDLE and DONE
// -----------------------------------------------------------------------------
module montexp_window
  import montexp_pkg::*;
#(
  parameter int WIDTH  = 1024,
  parameter int EWIDTH = 1024,
  parameter int WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  base,
  input  logic [EWIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]  modulus,
  input  logic [WIDTH-1:0]  n_prime,
  input  logic [WIDTH-1:0]  r2_mod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              busy
);

  localparam int D  = digit_count(EWIDTH, WINDOW);
  localparam int IW = idx_width(D);
  localparam int TD = 1 << WINDOW;
  localparam int CW = WINDOW + 1;  // holds both 2^k-1 and k-1

  localparam logic [IW-1:0] LastIdx = IW'(D - 1);
  localparam logic [CW-1:0] LastTbl = CW'(TD - 1);
  localparam logic [CW-1:0] LastSqr = CW'(WINDOW - 1);

`ifdef MONTEXP_CT_EN
  localparam bit CtEn = 1'b1;
`else
  localparam bit CtEn = 1'b0;
`endif

  if ((EWIDTH % WINDOW) != 0) begin : g_bad_ewidth
    $error("montexp_window: EWIDTH must be a multiple of WINDOW");
  end
  if (WINDOW < 1 || WINDOW > 6) begin : g_bad_window
    $error("montexp_window: WINDOW must be in 1..6");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0]  base_q, mod_q, np_q, r2_q;
  logic [EWIDTH-1:0] exp_q;
  logic [WIDTH-1:0]  tbl_q [TD];
  logic [WIDTH-1:0]  acc_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q;
  logic              mm_wait_q;
  logic [WIDTH-1:0]  result_q;
  logic              out_valid_q;

  logic              mm_start, mm_done, mm_need;
  logic [WIDTH-1:0]  mm_a, mm_b, mm_result;
  logic [WINDOW-1:0] digit;
  logic [WINDOW-1:0] tbl_prev;
  logic [EWIDTH-1:0] exp_sh;
  logic              transfer;

  assign in_ready = (state_q == IDLE);
  assign transfer = in_valid && in_ready;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign tbl_prev = cnt_q[WINDOW-1:0] - WINDOW'(1);

  // Digit idx counted from the MSB; shifting past the end yields zero.
  always_comb begin
    exp_sh = exp_q << (int'(idx_q) * WINDOW);
    digit  = exp_sh[EWIDTH-1 -: WINDOW];
  end

  // Operand selection and start strobe. mm_wait_q is still set in the done
  // cycle, so a new start can never coincide with done.
  always_comb begin
    mm_a    = '0;
    mm_b    = '0;
    mm_need = 1'b0;
    unique case (state_q)
      TOMONT: begin
        mm_a    = (cnt_q == '0) ? WIDTH'(1) : base_q;
        mm_b    = r2_q;
        mm_need = 1'b1;
      end
      TABLE: begin
        mm_a    = tbl_q[tbl_prev];
        mm_b    = tbl_q[1];
        mm_need = 1'b1;
      end
      SQR: begin
        mm_a    = acc_q;
        mm_b    = acc_q;
        mm_need = 1'b1;
      end
      MUL: begin
        mm_a    = acc_q;
        mm_b    = tbl_q[digit];
        mm_need = CtEn || (digit != '0);
      end
      FROMMONT: begin
        mm_a    = acc_q;
        mm_b    = WIDTH'(1);
        mm_need = 1'b1;
      end
      default: ;
    endcase
    mm_start = mm_need && !mm_wait_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (transfer) state_d = TOMONT;
      TOMONT:   if (mm_done && cnt_q == CW'(1)) state_d = (WINDOW == 1) ? SCAN : TABLE;
      TABLE:    if (mm_done && cnt_q == LastTbl) state_d = SCAN;
      SCAN: begin
        if (CtEn) begin
          state_d = SQR;
        end else if (idx_q == LastIdx) begin
          // Last digit reached: either it is the only nonzero one, or all were zero.
          state_d = FROMMONT;
        end else if (digit != '0) begin
          state_d = SQR;
        end
      end
      SQR:      if (mm_done && cnt_q == LastSqr) state_d = MUL;
      MUL: begin
        if (!mm_need || mm_done) state_d = (idx_q == LastIdx) ? FROMMONT : SQR;
      end
      FROMMONT: if (mm_done) state_d = DONE;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the power table is a register array, so it is cleared by the async
  // reset like any other flop; a RAM macro would not allow this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      mod_q       <= '0;
      np_q        <= '0;
      r2_q        <= '0;
      exp_q       <= '0;
      for (int i = 0; i < TD; i++) tbl_q[i] <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mm_wait_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (mm_start)     mm_wait_q <= 1'b1;
      else if (mm_done) mm_wait_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            base_q <= base;
            mod_q  <= modulus;
            np_q   <= n_prime;
            r2_q   <= r2_mod;
            exp_q  <= exponent;
            cnt_q  <= '0;
            idx_q  <= '0;
          end
        end
        TOMONT, TABLE: begin
          // cnt_q doubles as the table write pointer: 0 = one, 1 = bm, 2.. = powers.
          if (mm_done) begin
            tbl_q[cnt_q[WINDOW-1:0]] <= mm_result;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SCAN: begin
          cnt_q <= '0;
          if (CtEn) begin
            acc_q <= tbl_q[0];
          end else begin
            idx_q <= idx_q + IW'(1);
            if (digit != '0)            acc_q <= tbl_q[digit];
            else if (idx_q == LastIdx)  acc_q <= tbl_q[0];
          end
        end
        SQR: begin
          if (mm_done) begin
            acc_q <= mm_result;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        MUL: begin
          cnt_q <= '0;
          if (!mm_need || mm_done) idx_q <= idx_q + IW'(1);
          if (mm_done)             acc_q <= mm_result;
        end
        FROMMONT: begin
          if (mm_done) begin
            result_q    <= mm_result;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

  montmult #(
    .WIDTH (WIDTH)
  ) u_montmult (
    .clk     (clk),
    .rst     (rst),
    .start   (mm_start),
    .a       (mm_a),
    .b       (mm_b),
    .n       (mod_q),
    .n_prime (np_q),
    .result  (mm_result),
    .done    (mm_done)
  );

endmodule : montexp_window
